unpack_sig_stream: RTL
======================

// Module: unpack_sig_stream
// PURPOSE
//  Inverse of the signature packer: consumes a packed signature as a byte stream (c~ || z || h).
//  Captures c~, streams decoded z coefficients out and rebuilds the hint bitmap, with full malformed-hint checks.
//  Sits at the front of the verify datapath, between the signature byte source and the z/h consumers.
// PARAMETERS
//  CTILDEBYTES       48    bytes of challenge seed c~
//  L                 5     polys in z
//  K                 6     polys in h
//  N                 256   coeffs per poly
//  OMEGA             55    max total hint ones
//  POLYZ_PACKEDBYTES 640   bytes per packed z poly (20 bits/coeff, 2 coeffs per 5 bytes)
//  GAMMA1            524288  z offset (2^19)
//  BETA              196   z norm bound margin (used only with UNPACK_SIG_ZBOUND_EN)
// PORTS
//  clk      in   1                   clock, rising edge
//  rst      in   1                   asynchronous reset, active-high
//  start    in   1                   pulse: begin new signature (ignored while busy)
//  busy     out  1                   high from start accept until done
//  s_valid  in   1                   input byte valid
//  s_data   in   8                   input byte, signature order byte 0 first
//  s_ready  out  1                   input byte accepted when s_valid&s_ready
//  z_valid  out  1                   z coefficient valid
//  z_data   out  32                  z coeff, two's complement, order poly0 coeff0..poly L-1 coeff N-1
//  z_ready  in   1                   consumer accepts coefficient
//  c_out    out  CTILDEBYTES*8       c~, byte i at [8i+:8]
//  h_out    out  K*N                 hint bitmap, bit i*N+j = h[i][j]
//  done     out  1                   1-cycle pulse after last byte processed
//  err      out  1                   sticky malformed flag, valid at done, cleared by start
// BEHAVIOUR
//  Reset: busy,s_ready,z_valid,done,err=0; z_data,c_out,h_out=0; state IDLE.
//  start in IDLE: clear h_out,err; k=0; go S_C. c_out is not cleared (overwritten byte by byte).
//  FSM: IDLE -> S_C -> S_Z -> S_HIDX -> S_HCNT <-> S_HWALK -> S_HTAIL -> S_DONE -> IDLE.
//  S_C: CTILDEBYTES bytes into c_out; s_ready=1.
//  S_Z: gather 5 bytes into 40-bit t; t0=t[19:0], t1=t[39:20]; z=GAMMA1-t, sign-extended to 32.
//   After 5th byte: s_ready=0; present z0 then z1 (z_valid held, z_data stable until z_ready).
//   First z_valid cycle after the 5th byte handshake; 1 coeff/cycle when z_ready=1; resume input after z1 accepted.
//   L*N/2 groups total; no byte lost under arbitrary z_ready backpressure.
//  S_HIDX: OMEGA index bytes into idx[0..OMEGA-1]; s_ready=1.
//  S_HCNT: accept count byte cnt for poly i, then s_ready=0.
//   cnt<k or cnt>OMEGA: err=1, k unchanged, no walk; next poly.
//   else walk j=k..cnt-1 in S_HWALK, one j/cycle: if j>k and idx[j]<=idx[j-1] -> err=1, abort walk;
//   else h_out[i*N+idx[j]]=1. End: k=cnt. cnt==k: zero walk cycles.
//  S_HTAIL: after K counts, j=k..OMEGA-1 one/cycle; idx[j]!=0 -> err=1.
//  Once err=1, no further h_out writes; all remaining bytes still consumed (stream stays aligned).
//  S_DONE: done=1 one cycle, busy=0, -> IDLE. h_out/c_out hold until next start.
//  s_ready=0 in IDLE, S_HWALK, S_HTAIL, S_DONE, and while z pending. Total bytes = CTILDEBYTES+L*POLYZ_PACKEDBYTES+OMEGA+K.
//  Reset mid-operation: immediate return to reset values; partial signature discarded.
// CONFIGURATION
//  UNPACK_SIG_ZBOUND_EN defined: each z coeff also checked; |z| >= GAMMA1-BETA sets err (z still streamed).
//  Not defined: no z bound check; err reflects hint encoding only; BETA unused.
// TESTING
//  All-zero 3309 bytes -> 1280 z coeffs = 524288, h_out=0, err=0, one done pulse.
//  First z bytes FF FF FF FF FF -> z0=z1=-524287; bytes 00 00 08 00 00 -> z0=0, z1=524288.
//  idx=[3,7,0..], counts=[2,2,2,2,2,2] -> h_out bits 3,7 only, err=0.
//  idx=[7,3,..], counts=[2,...] -> err=1; count0=56 -> err=1; counts all 1 with idx[5]=9 -> err=1 (tail).
//  z_ready low 100 cycles mid-S_Z -> s_ready low, z_data stable, exact coeff sequence preserved.
//  rst pulse mid-S_Z -> all outputs reset; new start + full stream decodes correctly.
//  With UNPACK_SIG_ZBOUND_EN: t0=0 (z=524288) -> err=1; without macro same stream -> err=0.

Source files
------------

// File: rtl/unpack_sig_stream_if.sv
// Bus bundle for unpack_sig_stream: byte input stream, z coefficient output
// stream, control pulses and the decoded c~/hint results.
//
// Handshake rule (s_* and z_* streams alike): a transfer happens on a rising
// clock edge where valid and ready are both high. Once valid is raised, data
// stays stable and valid stays high until that edge; ready may toggle freely.
interface unpack_sig_stream_if #(
    parameter int CTILDEBYTES = 48,
    parameter int K           = 6,
    parameter int N           = 256
);
    logic                     start;
    logic                     busy;
    logic                     s_valid;
    logic [7:0]               s_data;
    logic                     s_ready;
    logic                     z_valid;
    logic [31:0]              z_data;
    logic                     z_ready;
    logic [CTILDEBYTES*8-1:0] c_out;
    logic [K*N-1:0]           h_out;
    logic                     done;
    logic                     err;
    logic [2:0]               dbg_state;

    modport master (
        output start, s_valid, s_data, z_ready,
        input  busy, s_ready, z_valid, z_data, c_out, h_out, done, err, dbg_state
    );

    modport slave (
        input  start, s_valid, s_data, z_ready,
        output busy, s_ready, z_valid, z_data, c_out, h_out, done, err, dbg_state
    );
endinterface

// File: rtl/unpack_sig_stream.sv
// unpack_sig_stream: splits a packed signature byte stream (c~ || z || h).
// c~ is captured into c_out, z is decoded and streamed out one coefficient at
// a time, and the hint section is rebuilt into the h_out bitmap while every
// malformed-encoding case raises the sticky err flag.
// Optional feature: define UNPACK_SIG_ZBOUND_EN to also flag any z coefficient
// with |z| >= GAMMA1-BETA (coefficients are still streamed out).
// The FSM state is visible on bus.dbg_state.
module unpack_sig_stream #(
    parameter int CTILDEBYTES       = 48,
    parameter int L                 = 5,
    parameter int K                 = 6,
    parameter int N                 = 256,
    parameter int OMEGA             = 55,
    parameter int POLYZ_PACKEDBYTES = 640,
    parameter int GAMMA1            = 524288,
    parameter int BETA              = 196
) (
    input  logic               clk,
    input  logic               rst,
    unpack_sig_stream_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, S_C, S_Z, S_HIDX, S_HCNT, S_HWALK, S_HTAIL, S_DONE
    } state_t;

    // Each 5-byte group carries two 20-bit coefficients.
    localparam int GROUPS = L * POLYZ_PACKEDBYTES / 5;
    localparam int GW     = $clog2(GROUPS);
    localparam int IW     = $clog2(OMEGA);
    localparam int CW     = $clog2(CTILDEBYTES * 8);
    localparam int HW     = $clog2(K * N);
    localparam int PW     = $clog2(K);

    localparam logic [7:0]    C_LAST  = 8'(CTILDEBYTES - 1);
    localparam logic [7:0]    O_LAST  = 8'(OMEGA - 1);
    localparam logic [7:0]    OMEGA_B = 8'(OMEGA);
    localparam logic [GW-1:0] G_LAST  = GW'(GROUPS - 1);
    localparam logic [PW-1:0] P_LAST  = PW'(K - 1);

    state_t                   state_q;
    logic [7:0]               cnt_q;      // byte index within c~ / index section
    logic [2:0]               zb_q;       // byte index within a z group
    logic [31:0]              t_q;        // first four bytes of the current z group
    logic [19:0]              t1_q;       // second coefficient of the group, raw
    logic                     zsel_q;     // 0: presenting z0, 1: presenting z1
    logic                     z_valid_q;
    logic [31:0]              z_data_q;
    logic [GW-1:0]            grp_q;
    logic [7:0]               idx_q [OMEGA];
    logic [PW-1:0]            poly_q;
    logic [7:0]               k_q;        // running hint count (end of previous poly)
    logic [7:0]               hcnt_q;     // count byte of the poly being walked
    logic [7:0]               j_q;        // walk / tail position
    logic                     err_q;
    logic [K*N-1:0]           h_q;
    logic [CTILDEBYTES*8-1:0] c_q;

    logic                     s_ready_c;
    logic                     s_fire;
    logic                     last_poly;
    logic                     hcnt_bad;
    logic                     walk_bad;
    logic [IW-1:0]            j_ix;
    logic [IW-1:0]            jm1_ix;
    logic [IW-1:0]            cnt_ix;
    logic [HW-1:0]            h_ix;
    logic [CW-1:0]            c_ix;
    logic [39:0]              t_full;
    logic [31:0]              z0_new;
    logic [31:0]              z1_new;

    // z = GAMMA1 - t, as a 32-bit two's complement value.
    function automatic logic [31:0] z_of(input logic [19:0] t);
        return 32'(GAMMA1) - {12'd0, t};
    endfunction

    // True when |z| reaches the rejection bound.
    function automatic logic z_out_of_bound(input logic [31:0] z);
        logic [31:0] mag;
        mag = z[31] ? (~z + 32'd1) : z;
        return mag >= 32'(GAMMA1 - BETA);
    endfunction

    // Datapath decodes shared by the FSM.
    always_comb begin
        s_ready_c = (state_q == S_C) || (state_q == S_HIDX) || (state_q == S_HCNT) ||
                    ((state_q == S_Z) && !z_valid_q);
        s_fire    = s_ready_c && bus.s_valid;
        last_poly = (poly_q == P_LAST);
        hcnt_bad  = (bus.s_data < k_q) || (bus.s_data > OMEGA_B);
        j_ix      = j_q[IW-1:0];
        jm1_ix    = IW'(j_q - 8'd1);
        cnt_ix    = cnt_q[IW-1:0];
        walk_bad  = (j_q != k_q) && (idx_q[j_ix] <= idx_q[jm1_ix]);
        h_ix      = HW'(poly_q) * HW'(N) + HW'(idx_q[j_ix]);
        c_ix      = CW'({cnt_q, 3'b000});
        t_full    = {bus.s_data, t_q};
        z0_new    = z_of(t_full[19:0]);
        z1_new    = z_of(t1_q);
    end

    // Hint index bytes; contents only matter after they are written.
    always_ff @(posedge clk) begin
        if ((state_q == S_HIDX) && s_fire) begin
            idx_q[cnt_ix] <= bus.s_data;
        end
    end

    // Main FSM with all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            zb_q      <= 3'd0;
            t_q       <= 32'd0;
            t1_q      <= 20'd0;
            zsel_q    <= 1'b0;
            z_valid_q <= 1'b0;
            z_data_q  <= 32'd0;
            grp_q     <= '0;
            poly_q    <= '0;
            k_q       <= 8'd0;
            hcnt_q    <= 8'd0;
            j_q       <= 8'd0;
            err_q     <= 1'b0;
            h_q       <= '0;
            c_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        h_q     <= '0;
                        err_q   <= 1'b0;
                        k_q     <= 8'd0;
                        cnt_q   <= 8'd0;
                        zb_q    <= 3'd0;
                        grp_q   <= '0;
                        zsel_q  <= 1'b0;
                        state_q <= S_C;
                    end
                end
                S_C: begin
                    if (s_fire) begin
                        c_q[c_ix +: 8] <= bus.s_data;
                        if (cnt_q == C_LAST) begin
                            cnt_q   <= 8'd0;
                            state_q <= S_Z;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                S_Z: begin
                    if (z_valid_q) begin
                        if (bus.z_ready) begin
                            if (!zsel_q) begin
                                z_data_q <= z1_new;
                                zsel_q   <= 1'b1;
`ifdef UNPACK_SIG_ZBOUND_EN
                                if (z_out_of_bound(z1_new)) err_q <= 1'b1;
`endif
                            end else begin
                                z_valid_q <= 1'b0;
                                zsel_q    <= 1'b0;
                                if (grp_q == G_LAST) begin
                                    grp_q   <= '0;
                                    cnt_q   <= 8'd0;
                                    state_q <= S_HIDX;
                                end else begin
                                    grp_q <= grp_q + 1'b1;
                                end
                            end
                        end
                    end else if (s_fire) begin
                        if (zb_q == 3'd4) begin
                            zb_q      <= 3'd0;
                            t1_q      <= t_full[39:20];
                            z_data_q  <= z0_new;
                            z_valid_q <= 1'b1;
`ifdef UNPACK_SIG_ZBOUND_EN
                            if (z_out_of_bound(z0_new)) err_q <= 1'b1;
`endif
                        end else begin
                            t_q[{zb_q[1:0], 3'b000} +: 8] <= bus.s_data;
                            zb_q <= zb_q + 3'd1;
                        end
                    end
                end
                S_HIDX: begin
                    if (s_fire) begin
                        if (cnt_q == O_LAST) begin
                            cnt_q   <= 8'd0;
                            poly_q  <= '0;
                            state_q <= S_HCNT;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                S_HCNT: begin
                    if (s_fire) begin
                        if (hcnt_bad) err_q <= 1'b1;
                        // Bad count or empty poly: no walk, k stays put.
                        if (hcnt_bad || (bus.s_data == k_q)) begin
                            if (last_poly) begin
                                j_q     <= k_q;
                                state_q <= (k_q == OMEGA_B) ? S_DONE : S_HTAIL;
                            end else begin
                                poly_q <= poly_q + 1'b1;
                            end
                        end else begin
                            hcnt_q  <= bus.s_data;
                            j_q     <= k_q;
                            state_q <= S_HWALK;
                        end
                    end
                end
                S_HWALK: begin
                    if (walk_bad) begin
                        err_q <= 1'b1;
                    end else if (!err_q) begin
                        h_q[h_ix] <= 1'b1;
                    end
                    if (walk_bad || (j_q == hcnt_q - 8'd1)) begin
                        k_q <= hcnt_q;
                        if (last_poly) begin
                            j_q     <= hcnt_q;
                            state_q <= (hcnt_q == OMEGA_B) ? S_DONE : S_HTAIL;
                        end else begin
                            poly_q  <= poly_q + 1'b1;
                            state_q <= S_HCNT;
                        end
                    end else begin
                        j_q <= j_q + 8'd1;
                    end
                end
                S_HTAIL: begin
                    // Unused index slots must be zero.
                    if (idx_q[j_ix] != 8'd0) err_q <= 1'b1;
                    if (j_q == O_LAST) begin
                        state_q <= S_DONE;
                    end else begin
                        j_q <= j_q + 8'd1;
                    end
                end
                S_DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (state_q != IDLE) && (state_q != S_DONE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.s_ready   = s_ready_c;
    assign bus.z_valid   = z_valid_q;
    assign bus.z_data    = z_data_q;
    assign bus.c_out     = c_q;
    assign bus.h_out     = h_q;
    assign bus.err       = err_q;
    assign bus.dbg_state = state_q;
endmodule
